// File: rtl/wb_stream_mem.sv
// Multi-lane weight/bias store: streams one wide beat per word of the selected layer
// under valid/ready, with a CPU-side write port usable only while idle.
module wb_stream_mem #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NLANE    = 32,
  parameter int unsigned L2_LANES = 10,
  parameter int unsigned L1_LEN   = 785,
  parameter int unsigned L2_LEN   = 33,
  parameter int unsigned AW       = $clog2(L1_LEN + L2_LEN),
  parameter int unsigned LANE_W   = (NLANE > 1) ? $clog2(NLANE) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      layer_sel,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NLANE*DATA_W-1:0]   out_data,
  output logic [AW-1:0]             out_idx,
  output logic                      out_last,
  input  logic                      wr_en,
  input  logic [LANE_W-1:0]         wr_lane,
  input  logic                      wr_layer,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_err
);

  localparam int unsigned Depth = L1_LEN + L2_LEN;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q;
  logic            layer_q;
  logic [AW-1:0]   cnt_q;
  logic [AW-1:0]   last_q;
  logic [AW-1:0]   base_q;

  logic            issue;
  logic [AW-1:0]   rd_addr;
  logic            wr_bad;
  logic            wr_ok;
  logic [AW-1:0]   wr_phys;

  assign issue   = (state_q == StRun) && (!out_valid || out_ready);
  assign rd_addr = base_q + cnt_q;

  always_comb begin
    wr_bad = busy || (32'(wr_lane) >= NLANE);
    if (wr_layer) begin
      wr_bad = wr_bad || (32'(wr_addr) >= L2_LEN) || (32'(wr_lane) >= L2_LANES);
    end else begin
      wr_bad = wr_bad || (32'(wr_addr) >= L1_LEN);
    end
  end

  assign wr_ok   = wr_en && !wr_bad;
  assign wr_phys = wr_layer ? (AW'(L1_LEN) + wr_addr) : wr_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && wr_bad;
    end
  end

  // Stream sequencer; every output it drives is registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      layer_q   <= 1'b0;
      cnt_q     <= '0;
      last_q    <= '0;
      base_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            layer_q <= layer_sel;
            last_q  <= layer_sel ? AW'(L2_LEN - 1) : AW'(L1_LEN - 1);
            base_q  <= layer_sel ? AW'(L1_LEN) : '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (issue) begin
            out_valid <= 1'b1;
            out_idx   <= cnt_q;
            out_last  <= (cnt_q == last_q);
            if (cnt_q == last_q) begin
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + AW'(1);
            end
          end
        end
        StDrain: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    // Lanes beyond L2_LANES have no layer-2 neuron and read as zero there.
    localparam bit Gated = (k >= L2_LANES);

    logic [DATA_W-1:0] ram [Depth];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_ok && (wr_lane == LANE_W'(k))) begin
        ram[wr_phys] <= wr_data;
      end
    end

    // Only loads on issue, so the beat holds steady while stalled.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_q <= '0;
      end else if (issue) begin
        rd_q <= (layer_q && Gated) ? '0 : ram[rd_addr];
      end
    end

    assign out_data[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_wb_stream_mem.sv
// Randomised bench for wb_stream_mem: a lane/word array model predicts every streamed beat.
module tb_wb_stream_mem;

  localparam int DW   = 32;
  localparam int NL   = 32;
  localparam int L2L  = 10;
  localparam int LEN1 = 785;
  localparam int LEN2 = 33;
  localparam int AW   = 10;
  localparam int LW   = 5;
  localparam int NW   = NL * DW;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          layer_sel = 1'b0;
  logic          out_ready = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_layer = 1'b0;
  logic [LW-1:0] wr_lane = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          busy, done, out_valid, out_last, wr_err;
  logic [NW-1:0] out_data;
  logic [AW-1:0] out_idx;

  always #5 clk = ~clk;

  wb_stream_mem #(
    .DATA_W  (DW),
    .NLANE   (NL),
    .L2_LANES(L2L),
    .L1_LEN  (LEN1),
    .L2_LEN  (LEN2),
    .AW      (AW),
    .LANE_W  (LW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .layer_sel(layer_sel),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .wr_en    (wr_en),
    .wr_lane  (wr_lane),
    .wr_layer (wr_layer),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err)
  );

  int vec = 0;
  int miss = 0;

  logic [DW-1:0] m1 [NL][LEN1];
  logic [DW-1:0] m2 [NL][LEN2];

  int            got_idx  [$];
  logic [NW-1:0] got_data [$];
  bit            got_last [$];
  int first_cyc, done_cyc, last_hs_cyc, stall_viol, done_pulses;
  bit timeout, poke_err, aborted, busy_c1, busy_at_done;
  logic          r_valid, r_busy, r_last, r_done;
  logic [AW-1:0] r_idx;
  logic [NW-1:0] r_data;

  function automatic logic [NW-1:0] exp_row(input bit layer, input int i);
    logic [NW-1:0] r = '0;
    for (int k = 0; k < NL; k++) begin
      if (!layer) r[k*DW +: DW] = m1[k][i];
      else if (k < L2L) r[k*DW +: DW] = m2[k][i];
    end
    return r;
  endfunction

  function automatic bit ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
    return 1'(($urandom & 32'd3) != 0);
  endfunction

  task automatic do_write(input int lane, input bit layer, input int addr, input logic [DW-1:0] d,
                          output bit err);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_lane = LW'(lane); wr_layer = layer; wr_addr = AW'(addr); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    err = wr_err;
  endtask

  task automatic preload();
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < LEN1; i++) begin
        m1[k][i] = {k[7:0], i[23:0]};
        @(posedge clk); #1;
        wr_en = 1'b1; wr_lane = LW'(k); wr_layer = 1'b0; wr_addr = AW'(i); wr_data = m1[k][i];
      end
      if (k < L2L) begin
        for (int i = 0; i < LEN2; i++) begin
          m2[k][i] = {k[7:0] + 8'h40, 24'h00a000 + i[23:0]};
          @(posedge clk); #1;
          wr_en = 1'b1; wr_lane = LW'(k); wr_layer = 1'b1; wr_addr = AW'(i); wr_data = m2[k][i];
        end
      end
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Runs one stream and records what the DUT presented; the test tasks judge it.
  task automatic collect(input bit layer, input int mode, input int poke_beat, input int abort_beat);
    int cyc, poke_cyc, tail;
    bit prev_stall, poked;
    logic [NW-1:0] pdata;
    logic [AW-1:0] pidx;
    logic plast;
    got_idx.delete(); got_data.delete(); got_last.delete();
    first_cyc = -1; done_cyc = -1; last_hs_cyc = -1; stall_viol = 0; done_pulses = 0;
    timeout = 0; poke_err = 0; aborted = 0; busy_c1 = 0; busy_at_done = 1;
    prev_stall = 0; poked = 0; poke_cyc = -1; tail = -1;
    pdata = '0; pidx = '0; plast = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; layer_sel = layer; out_ready = ready_for(mode, 0);
    for (cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (cyc == 1) busy_c1 = busy;
      if (poke_cyc >= 0 && cyc == poke_cyc + 1) poke_err = wr_err;
      if (prev_stall && !(out_valid === 1'b1 && out_idx === pidx && out_data === pdata &&
                          out_last === plast)) stall_viol++;
      prev_stall = out_valid && !out_ready;
      pidx = out_idx; pdata = out_data; plast = out_last;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin
          done_cyc = cyc; busy_at_done = busy; tail = cyc + 2;
        end
      end
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        if (first_cyc < 0) first_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (abort_beat >= 0 && got_idx.size() == abort_beat) begin
        resetn = 1'b0;
        #1;
        r_valid = out_valid; r_busy = busy; r_last = out_last; r_done = done;
        r_idx = out_idx; r_data = out_data;
        aborted = 1;
        break;
      end
      if (tail >= 0 && cyc >= tail) break;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      out_ready = ready_for(mode, cyc + 1);
      if (poke_beat >= 0 && !poked && got_idx.size() >= poke_beat) begin
        poked = 1; poke_cyc = cyc + 1;
        start = 1'b1; layer_sel = ~layer;
        wr_en = 1'b1; wr_lane = LW'(3); wr_layer = 1'b0; wr_addr = AW'(700);
        wr_data = 32'h12345678;
      end
    end
    if (cyc >= BUDGET) timeout = 1;
    start = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL reset_done: got %b want 0", done); end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec++; if (out_last !== 1'b0) begin miss++; $display("FAIL reset_last: got %b want 0", out_last); end
    vec++; if (out_idx !== '0) begin miss++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    vec++; if (out_data !== '0) begin miss++; $display("FAIL reset_data: got %0h want 0", out_data); end
    vec++; if (wr_err !== 1'b0) begin miss++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    resetn = 1'b1;
  endtask

  task automatic test_layer1_stream();
    logic [DW-1:0] w;
    collect(1'b0, 0, -1, -1);
    vec++; if (timeout) begin miss++; $display("FAIL l1_timeout: got 1 want 0"); end
    vec++; if (got_idx.size() != LEN1) begin
      miss++; $display("FAIL l1_beats: got %0d want %0d", got_idx.size(), LEN1); end
    for (int i = 0; i < got_idx.size() && i < LEN1; i++) begin
      vec++; if (got_idx[i] != i) begin miss++; $display("FAIL l1_idx[%0d]: got %0d want %0d", i, got_idx[i], i); end
      vec++; if (got_data[i] !== exp_row(0, i)) begin
        miss++; $display("FAIL l1_data[%0d]: got %0h want %0h", i, got_data[i], exp_row(0, i)); end
      vec++; if (got_last[i] != (i == LEN1 - 1)) begin
        miss++; $display("FAIL l1_last[%0d]: got %b want %b", i, got_last[i], i == LEN1 - 1); end
    end
    if (got_data.size() > 100) begin
      w = got_data[100][5*DW +: DW];
      vec++; if (w !== 32'h05000064) begin miss++; $display("FAIL l1_lane5_beat100: got %0h want 05000064", w); end
    end
    vec++; if (first_cyc != 2) begin miss++; $display("FAIL l1_first_beat_cycle: got %0d want 2", first_cyc); end
    vec++; if (last_hs_cyc != 2 + LEN1 - 1) begin
      miss++; $display("FAIL l1_last_beat_cycle: got %0d want %0d", last_hs_cyc, 2 + LEN1 - 1); end
    vec++; if (done_cyc != last_hs_cyc + 1) begin
      miss++; $display("FAIL l1_done_cycle: got %0d want %0d", done_cyc, last_hs_cyc + 1); end
    vec++; if (done_pulses != 1) begin miss++; $display("FAIL l1_done_pulses: got %0d want 1", done_pulses); end
    vec++; if (busy_at_done !== 1'b0) begin miss++; $display("FAIL l1_busy_at_done: got %b want 0", busy_at_done); end
    vec++; if (busy_c1 !== 1'b1) begin miss++; $display("FAIL l1_busy_after_start: got %b want 1", busy_c1); end
  endtask

  task automatic test_layer2_stall();
    collect(1'b1, 1, -1, -1);
    vec++; if (timeout) begin miss++; $display("FAIL l2_timeout: got 1 want 0"); end
    vec++; if (got_idx.size() != LEN2) begin
      miss++; $display("FAIL l2_beats: got %0d want %0d", got_idx.size(), LEN2); end
    for (int i = 0; i < got_idx.size() && i < LEN2; i++) begin
      vec++; if (got_idx[i] != i) begin miss++; $display("FAIL l2_idx[%0d]: got %0d want %0d", i, got_idx[i], i); end
      vec++; if (got_data[i] !== exp_row(1, i)) begin
        miss++; $display("FAIL l2_data[%0d]: got %0h want %0h", i, got_data[i], exp_row(1, i)); end
      vec++; if ((got_data[i] >> (L2L * DW)) !== '0) begin
        miss++; $display("FAIL l2_upper_lanes[%0d]: got %0h want 0", i, got_data[i] >> (L2L * DW)); end
      vec++; if (got_last[i] != (i == LEN2 - 1)) begin
        miss++; $display("FAIL l2_last[%0d]: got %b want %b", i, got_last[i], i == LEN2 - 1); end
    end
    vec++; if (stall_viol != 0) begin miss++; $display("FAIL l2_stall_hold: got %0d changes want 0", stall_viol); end
    vec++; if (done_pulses != 1) begin miss++; $display("FAIL l2_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_writes();
    bit err;
    logic [DW-1:0] w;
    do_write(3, 0, 784, 32'hdeadbeef, err);
    m1[3][784] = 32'hdeadbeef;
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL wr_good_err: got %b want 0", err); end
    do_write(9, 1, 32, 32'hcafe0009, err);
    m2[9][32] = 32'hcafe0009;
    vec++; if (err !== 1'b0) begin miss++; $display("FAIL wr_good_l2_err: got %b want 0", err); end
    do_write(0, 0, 785, 32'h11111111, err);
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL wr_addr_range_err: got %b want 1", err); end
    do_write(12, 1, 0, 32'h22222222, err);
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL wr_l2_lane_err: got %b want 1", err); end
    do_write(2, 1, 33, 32'h33333333, err);
    vec++; if (err !== 1'b1) begin miss++; $display("FAIL wr_l2_addr_err: got %b want 1", err); end
    collect(1'b0, 0, -1, -1);
    vec++; if (got_idx.size() != LEN1) begin
      miss++; $display("FAIL wr_l1_beats: got %0d want %0d", got_idx.size(), LEN1); end
    for (int i = 0; i < got_idx.size() && i < LEN1; i++) begin
      vec++; if (got_data[i] !== exp_row(0, i)) begin
        miss++; $display("FAIL wr_l1_data[%0d]: got %0h want %0h", i, got_data[i], exp_row(0, i)); end
    end
    if (got_data.size() == LEN1) begin
      w = got_data[784][3*DW +: DW];
      vec++; if (w !== 32'hdeadbeef) begin miss++; $display("FAIL wr_beat784_lane3: got %0h want deadbeef", w); end
    end
    collect(1'b1, 0, -1, -1);
    vec++; if (got_idx.size() != LEN2) begin
      miss++; $display("FAIL wr_l2_beats: got %0d want %0d", got_idx.size(), LEN2); end
    for (int i = 0; i < got_idx.size() && i < LEN2; i++) begin
      vec++; if (got_data[i] !== exp_row(1, i)) begin
        miss++; $display("FAIL wr_l2_data[%0d]: got %0h want %0h", i, got_data[i], exp_row(1, i)); end
    end
  endtask

  task automatic test_busy_poke();
    collect(1'b0, 0, 50, -1);
    vec++; if (poke_err !== 1'b1) begin miss++; $display("FAIL busy_wr_err: got %b want 1", poke_err); end
    vec++; if (got_idx.size() != LEN1) begin
      miss++; $display("FAIL busy_beats: got %0d want %0d", got_idx.size(), LEN1); end
    for (int i = 0; i < got_idx.size() && i < LEN1; i++) begin
      vec++; if (got_idx[i] != i || got_data[i] !== exp_row(0, i)) begin
        miss++; $display("FAIL busy_beat[%0d]: got idx %0d data %0h want idx %0d data %0h",
                         i, got_idx[i], got_data[i], i, exp_row(0, i)); end
    end
    vec++; if (done_pulses != 1) begin miss++; $display("FAIL busy_done_pulses: got %0d want 1", done_pulses); end
  endtask

  task automatic test_random();
    bit err, exp_err, l;
    int lane, addr;
    logic [DW-1:0] d;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 16; n++) begin
        l = 1'($urandom & 1);
        lane = int'($urandom_range(0, NL - 1));
        addr = int'($urandom_range(0, l ? LEN2 + 8 : LEN1 + 8));
        d = $urandom;
        exp_err = l ? (addr >= LEN2 || lane >= L2L) : (addr >= LEN1);
        do_write(lane, l, addr, d, err);
        vec++; if (err !== exp_err) begin
          miss++; $display("FAIL rnd_wr_err lane %0d layer %0d addr %0d: got %b want %b",
                           lane, l, addr, err, exp_err); end
        if (!exp_err) begin
          if (l) m2[lane][addr] = d; else m1[lane][addr] = d;
        end
      end
      l = 1'(r & 1);
      collect(l, 2, -1, -1);
      vec++; if (timeout) begin miss++; $display("FAIL rnd_timeout: got 1 want 0"); end
      vec++; if (got_idx.size() != (l ? LEN2 : LEN1)) begin
        miss++; $display("FAIL rnd_beats: got %0d want %0d", got_idx.size(), l ? LEN2 : LEN1); end
      for (int i = 0; i < got_idx.size(); i++) begin
        vec++; if (got_idx[i] != i || got_data[i] !== exp_row(l, i) ||
                   got_last[i] != (i == (l ? LEN2 : LEN1) - 1)) begin
          miss++; $display("FAIL rnd_beat[%0d]: got idx %0d last %b data %0h want data %0h",
                           i, got_idx[i], got_last[i], got_data[i], exp_row(l, i)); end
      end
      vec++; if (stall_viol != 0) begin miss++; $display("FAIL rnd_stall_hold: got %0d want 0", stall_viol); end
    end
  endtask

  task automatic test_reset_mid();
    collect(1'b0, 0, -1, 400);
    vec++; if (!aborted) begin miss++; $display("FAIL rst_mid_reached: got 0 want 1"); end
    vec++; if (r_valid !== 1'b0) begin miss++; $display("FAIL rst_mid_valid: got %b want 0", r_valid); end
    vec++; if (r_busy !== 1'b0) begin miss++; $display("FAIL rst_mid_busy: got %b want 0", r_busy); end
    vec++; if (r_last !== 1'b0) begin miss++; $display("FAIL rst_mid_last: got %b want 0", r_last); end
    vec++; if (r_done !== 1'b0) begin miss++; $display("FAIL rst_mid_done: got %b want 0", r_done); end
    vec++; if (r_idx !== '0) begin miss++; $display("FAIL rst_mid_idx: got %0d want 0", r_idx); end
    vec++; if (r_data !== '0) begin miss++; $display("FAIL rst_mid_data: got %0h want 0", r_data); end
    @(posedge clk); #1;
    resetn = 1'b1;
    collect(1'b0, 0, -1, -1);
    vec++; if (got_idx.size() != LEN1) begin
      miss++; $display("FAIL rst_after_beats: got %0d want %0d", got_idx.size(), LEN1); end
    vec++; if (first_cyc != 2) begin miss++; $display("FAIL rst_after_first: got %0d want 2", first_cyc); end
    for (int i = 0; i < got_idx.size() && i < LEN1; i++) begin
      vec++; if (got_idx[i] != i || got_data[i] !== exp_row(0, i)) begin
        miss++; $display("FAIL rst_after_beat[%0d]: got idx %0d data %0h want data %0h",
                         i, got_idx[i], got_data[i], exp_row(0, i)); end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_layer1_stream();
    test_layer2_stall();
    test_writes();
    test_busy_poke();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
